traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 125_000_000, clock cycles per time tick (1 in simulation).
REQ-002 The block SHALL have parameter YELLOW_T, default 3, required yellow duration in ticks.
REQ-003 The block SHALL have parameter MIN_GREEN, default 10, minimum green duration in ticks for either road.
REQ-004 The block SHALL have port clk_125M, input, 1 bit, single clock; one clock, all logic on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port HL, input, 3 bits, highway lamps: [2] green, [1] yellow, [0] red.
REQ-007 The block SHALL have port FL, input, 3 bits, farm-road lamps, same encoding as HL.
REQ-008 The block SHALL have port clr, input, 1 bit, synchronous clear of the sticky error flags.
REQ-009 The block SHALL have port err_code, output, 3 bits, sticky: [0] non-one-hot lamp, [1] both roads non-red (conflict), [2] illegal transition.
REQ-010 The block SHALL have port err_time, output, 2 bits, sticky: [0] yellow duration is not YELLOW_T, [1] green shorter than MIN_GREEN.
REQ-011 The block SHALL have port viol, output, 1 bit, one-cycle pulse on any newly detected violation.
REQ-012 The block SHALL have port h_green_cnt, output, 8 bits, count of highway green phases entered; saturates at 255.
REQ-013 The block SHALL have port phase_ticks, output, 16 bits, ticks elapsed in the current highway lamp state; saturates at 65535.

Function
REQ-014 A free-running prescaler SHALL count 0..TICK_DIV-1 and emit a one-cycle tick at terminal count, then wrap to 0.
REQ-015 Per road, the block SHALL register the previous lamp value (prev_H, prev_F) plus a prev_valid bit, and SHALL evaluate checks on each cycle's sampled inputs against prev.
REQ-016 All outputs SHALL be registered, with one-cycle latency: a violation present on the inputs at edge N SHALL be reflected on outputs after edge N.
REQ-017 err_code[0] SHALL set when HL or FL is not exactly one-hot (includes 3'b000).
REQ-018 err_code[1] SHALL set when HL[0]==0 and FL[0]==0 in the same cycle, regardless of one-hot validity.
REQ-019 Per road, the legal changes SHALL be G->Y, Y->R and R->G; an unchanged value is legal, and any other change SHALL set err_code[2].
REQ-020 Transition checks SHALL only run when prev_valid==1 and both the previous and current values are one-hot.
REQ-021 Per road, a tick counter SHALL clear on every lamp change and increment on each tick while the lamp is unchanged.
REQ-022 On a Y->R change, err_time[0] SHALL set if the counter is not equal to YELLOW_T.
REQ-023 On a G->Y change, err_time[1] SHALL set if the counter is less than MIN_GREEN.
REQ-024 Per road, a lamp change and a tick in the same cycle SHALL clear the counter, i.e. the tick is credited to the new state.
REQ-025 Simultaneous HL and FL changes SHALL each be checked independently, and all resulting flags SHALL set in the same cycle.
REQ-026 viol SHALL be 1 for one cycle when any err bit goes 0->1; a violation whose bit is already set SHALL NOT pulse viol.
REQ-027 When clr is asserted, all sticky flags SHALL clear; a violation in the same cycle as clr SHALL win, leaving its bit set and pulsing viol.
REQ-028 h_green_cnt SHALL increment on every highway R->G change, and also on the first valid sample when that sample is green.
REQ-029 phase_ticks SHALL mirror the highway tick counter.

Reset
REQ-030 While rst==1, err_code=0, err_time=0, viol=0, h_green_cnt=0, phase_ticks=0, the prescaler is 0, the road counters are 0 and prev_valid=0.
REQ-031 The first cycle after rst deasserts SHALL establish the baseline: no transition or duration check runs, while the one-hot and conflict checks run.
REQ-032 Assertion of rst mid-phase SHALL abandon all timing, and SHALL NOT raise any flag for the truncated phase.

Verification
REQ-033 TICK_DIV=1, legal cycle HL=G(12 cycles)/FL=R, then HL=Y(3), then HL=R/FL=G(12), then FL=Y(3) -> all err bits stay 0, h_green_cnt=1, viol never pulses.
REQ-034 HL=G while FL=G for 1 cycle -> err_code=3'b010 on the next cycle, viol pulses once; holding the condition 5 more cycles produces no further pulse.
REQ-035 HL G->R directly -> err_code[2]=1; HL=3'b110 -> err_code[0]=1.
REQ-036 Highway yellow held 2 ticks -> err_time[0]=1; highway green held 4 ticks then G->Y -> err_time[1]=1.
REQ-037 clr pulsed while a conflict is asserted on the same cycle -> err_code[1] stays 1 and viol pulses; clr alone -> all flags 0.
REQ-038 rst asserted mid-yellow, then released with HL=R -> no err_time flag, phase_ticks restarts from 0, h_green_cnt=0.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Intersection lamp monitor: checks one-hot lamps, road conflicts, illegal
// sequencing and phase durations, with sticky flags and a highway phase timer.
module traffic_light_monitor #(
  parameter int TICK_DIV  = 125_000_000,
  parameter int YELLOW_T  = 3,
  parameter int MIN_GREEN = 10
) (
  input  logic        clk_125M,
  input  logic        rst,
  input  logic [2:0]  HL,
  input  logic [2:0]  FL,
  input  logic        clr,
  output logic [2:0]  err_code,
  output logic [1:0]  err_time,
  output logic        viol,
  output logic [7:0]  h_green_cnt,
  output logic [15:0] phase_ticks
);

  localparam int            PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(TICK_DIV - 1);
  localparam logic [15:0]   YT     = 16'(YELLOW_T);
  localparam logic [15:0]   MG     = 16'(MIN_GREEN);
  localparam logic [2:0]    LG     = 3'b100;
  localparam logic [2:0]    LY     = 3'b010;
  localparam logic [2:0]    LR     = 3'b001;

  function automatic logic f_onehot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  logic [PW-1:0]    r_pre;
  logic             w_tick;
  logic             r_pv;
  logic [1:0][2:0]  w_lamp;
  logic [1:0][2:0]  r_prev;
  logic [1:0][15:0] r_cnt;
  logic [1:0]       w_chg, w_chk, w_g2y, w_y2r, w_r2g;
  logic [1:0]       w_bad_oh, w_trans_err, w_yel_err, w_grn_err;
  logic [2:0]       w_det_code, w_base_code, r_err_code;
  logic [1:0]       w_det_time, w_base_time, r_err_time;
  logic             r_viol;
  logic [7:0]       r_hg;
  logic             w_hg_inc;

  // Road index 0 is the highway, 1 the farm road.
  assign w_lamp = {FL, HL};
  assign w_tick = (r_pre == PRE_TC);

  always_comb begin
    w_chg       = '0;
    w_chk       = '0;
    w_g2y       = '0;
    w_y2r       = '0;
    w_r2g       = '0;
    w_bad_oh    = '0;
    w_trans_err = '0;
    w_yel_err   = '0;
    w_grn_err   = '0;
    for (int g = 0; g < 2; g++) begin
      w_bad_oh[g]    = !f_onehot(w_lamp[g]);
      w_chg[g]       = r_pv && (w_lamp[g] != r_prev[g]);
      w_chk[g]       = r_pv && f_onehot(w_lamp[g]) && f_onehot(r_prev[g]);
      w_g2y[g]       = w_chk[g] && (r_prev[g] == LG) && (w_lamp[g] == LY);
      w_y2r[g]       = w_chk[g] && (r_prev[g] == LY) && (w_lamp[g] == LR);
      w_r2g[g]       = w_chk[g] && (r_prev[g] == LR) && (w_lamp[g] == LG);
      w_trans_err[g] = w_chk[g] && w_chg[g] && !(w_g2y[g] || w_y2r[g] || w_r2g[g]);
      w_yel_err[g]   = w_y2r[g] && (r_cnt[g] != YT);
      w_grn_err[g]   = w_g2y[g] && (r_cnt[g] < MG);
    end
    w_det_code  = {|w_trans_err, !HL[0] && !FL[0], |w_bad_oh};
    w_det_time  = {|w_grn_err, |w_yel_err};
    // clr drops the old flags first so a same-cycle violation re-sets and pulses.
    w_base_code = clr ? 3'b000 : r_err_code;
    w_base_time = clr ? 2'b00  : r_err_time;
    w_hg_inc    = w_r2g[0] || (!r_pv && (HL == LG));
  end

  always_ff @(posedge clk_125M) begin
    if (rst) begin
      r_pre      <= '0;
      r_pv       <= 1'b0;
      r_prev     <= '0;
      r_cnt      <= '0;
      r_err_code <= '0;
      r_err_time <= '0;
      r_viol     <= 1'b0;
      r_hg       <= '0;
    end else begin
      r_pre      <= w_tick ? '0 : r_pre + 1'b1;
      r_pv       <= 1'b1;
      r_err_code <= w_base_code | w_det_code;
      r_err_time <= w_base_time | w_det_time;
      r_viol     <= (|(w_det_code & ~w_base_code)) || (|(w_det_time & ~w_base_time));
      if (w_hg_inc && (r_hg != 8'hFF))
        r_hg <= r_hg + 8'd1;
      for (int g = 0; g < 2; g++) begin
        r_prev[g] <= w_lamp[g];
        // A tick landing on the change edge is counted for the new lamp state.
        if (!r_pv)
          r_cnt[g] <= '0;
        else if (w_chg[g])
          r_cnt[g] <= {15'd0, w_tick};
        else if (w_tick && (r_cnt[g] != 16'hFFFF))
          r_cnt[g] <= r_cnt[g] + 16'd1;
      end
    end
  end

  assign err_code    = r_err_code;
  assign err_time    = r_err_time;
  assign viol        = r_viol;
  assign h_green_cnt = r_hg;
  assign phase_ticks = r_cnt[0];

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized lamp
// sequences checked against a rule-level reference model (two parameter sets).
module tb_traffic_light_monitor;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] HL = R, FL = R;
  logic clr = 1'b0;

  logic [2:0] err_code, e1_code;
  logic [1:0] err_time, e1_time;
  logic viol, e1_viol;
  logic [7:0] h_green_cnt, e1_hg;
  logic [15:0] phase_ticks, e1_pt;

  int errors = 0;
  int checks = 0;
  int viol_seen = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(.TICK_DIV(1), .YELLOW_T(3), .MIN_GREEN(10)) dut0 (
    .clk_125M(clk), .rst(rst), .HL(HL), .FL(FL), .clr(clr),
    .err_code(err_code), .err_time(err_time), .viol(viol),
    .h_green_cnt(h_green_cnt), .phase_ticks(phase_ticks));

  traffic_light_monitor #(.TICK_DIV(3), .YELLOW_T(2), .MIN_GREEN(4)) dut1 (
    .clk_125M(clk), .rst(rst), .HL(HL), .FL(FL), .clr(clr),
    .err_code(e1_code), .err_time(e1_time), .viol(e1_viol),
    .h_green_cnt(e1_hg), .phase_ticks(e1_pt));

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0] ph, pf;
    int ch, cf;
    bit pv;
    logic [2:0] code;
    logic [1:0] tim;
    bit viol;
    int hg, pre;
  } mstate_t;

  mstate_t m0, m1;

  function automatic mstate_t mzero();
    mstate_t z;
    z.ph = 3'b000; z.pf = 3'b000; z.ch = 0; z.cf = 0; z.pv = 1'b0;
    z.code = 3'b000; z.tim = 2'b00; z.viol = 1'b0; z.hg = 0; z.pre = 0;
    return z;
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] l);
    case (l)
      G: return Y;
      Y: return R;
      default: return G;
    endcase
  endfunction

  // One road's lamp history for one cycle: what the change means and the new phase length.
  function automatic void road_step(input logic [2:0] prev, input logic [2:0] cur,
      input int cnt, input bit pv, input bit tick, input int yt, input int mg,
      output bit bad_trans, output bit yel_bad, output bit grn_bad,
      output bit entered_green, output int ncnt);
    bad_trans = 0; yel_bad = 0; grn_bad = 0; entered_green = 0; ncnt = cnt;
    if (!pv) begin
      ncnt = 0;
      return;
    end
    if (cur != prev) begin
      ncnt = tick ? 1 : 0;
      if ($countones(prev) == 1 && $countones(cur) == 1) begin
        if (cur != succ(prev)) bad_trans = 1;
        else begin
          yel_bad = (prev == Y) && (cnt != yt);
          grn_bad = (prev == G) && (cnt < mg);
          entered_green = (cur == G);
        end
      end
    end else if (tick && cnt < 65535) begin
      ncnt = cnt + 1;
    end
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input bit r, input logic [2:0] hl,
      input logic [2:0] fl, input bit c, input int div, input int yt, input int mg);
    mstate_t n;
    bit tick, bt, yb, gb, eg;
    logic [2:0] dc, bc;
    logic [1:0] dt, btim;
    if (r) return mzero();
    n = s;
    tick = (s.pre == div - 1);
    n.pre = tick ? 0 : s.pre + 1;
    dc = 3'b000; dt = 2'b00;
    if ($countones(hl) != 1 || $countones(fl) != 1) dc[0] = 1'b1;
    if (!hl[0] && !fl[0]) dc[1] = 1'b1;
    road_step(s.ph, hl, s.ch, s.pv, tick, yt, mg, bt, yb, gb, eg, n.ch);
    dc[2] = dc[2] | bt; dt[0] = dt[0] | yb; dt[1] = dt[1] | gb;
    if (eg || (!s.pv && hl == G)) n.hg = (s.hg < 255) ? s.hg + 1 : 255;
    road_step(s.pf, fl, s.cf, s.pv, tick, yt, mg, bt, yb, gb, eg, n.cf);
    dc[2] = dc[2] | bt; dt[0] = dt[0] | yb; dt[1] = dt[1] | gb;
    bc = c ? 3'b000 : s.code;
    btim = c ? 2'b00 : s.tim;
    n.viol = ((dc & ~bc) != 3'b000) || ((dt & ~btim) != 2'b00);
    n.code = bc | dc;
    n.tim = btim | dt;
    n.ph = hl; n.pf = fl; n.pv = 1'b1;
    return n;
  endfunction

  initial begin
    m0 = mzero();
    m1 = mzero();
  end

  always @(posedge clk) begin
    m0 = mstep(m0, rst, HL, FL, clr, 1, 3, 10);
    m1 = mstep(m1, rst, HL, FL, clr, 3, 2, 4);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [2:0] h, input logic [2:0] f, input bit c, input int n);
    for (int i = 0; i < n; i++) begin
      HL = h; FL = f; clr = c;
      @(posedge clk);
      #1;
      viol_seen += int'(viol);
    end
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(R, R, 1'b0, 2);
    rst = 1'b0;
    viol_seen = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(G, G, 1'b0, 3);
    checks++; if ({err_code, err_time, viol} !== 6'b0) begin errors++; $display("FAIL reset_flags got=%b exp=000000", {err_code, err_time, viol}); end
    checks++; if (h_green_cnt !== 8'd0 || phase_ticks !== 16'd0) begin errors++; $display("FAIL reset_counts got hg=%0d pt=%0d exp 0 0", h_green_cnt, phase_ticks); end
    checks++; if ({e1_code, e1_time, e1_viol, e1_hg, e1_pt} !== 30'b0) begin errors++; $display("FAIL reset_dut1 got=%h exp=0", {e1_code, e1_time, e1_viol, e1_hg, e1_pt}); end
    rst = 1'b0;
  endtask

  task automatic test_legal_cycle();
    do_reset();
    drive(G, R, 1'b0, 12);
    drive(Y, R, 1'b0, 3);
    drive(R, G, 1'b0, 12);
    drive(R, Y, 1'b0, 3);
    drive(R, R, 1'b0, 2);
    checks++; if ({err_code, err_time} !== 5'b0) begin errors++; $display("FAIL legal_flags got=%b exp=00000", {err_code, err_time}); end
    checks++; if (h_green_cnt !== 8'd1) begin errors++; $display("FAIL legal_hgreen got=%0d exp=1", h_green_cnt); end
    checks++; if (viol_seen !== 0) begin errors++; $display("FAIL legal_viol got=%0d pulses exp=0", viol_seen); end
    checks++; if (phase_ticks !== 16'd17) begin errors++; $display("FAIL legal_phase got=%0d exp=17", phase_ticks); end
  endtask

  task automatic test_conflict();
    do_reset();
    drive(G, R, 1'b0, 3);
    drive(G, G, 1'b0, 1);
    checks++; if (err_code !== 3'b010) begin errors++; $display("FAIL conflict_code got=%b exp=010", err_code); end
    checks++; if (viol !== 1'b1) begin errors++; $display("FAIL conflict_viol got=%b exp=1", viol); end
    viol_seen = 0;
    drive(G, G, 1'b0, 5);
    checks++; if (viol_seen !== 0) begin errors++; $display("FAIL conflict_hold_viol got=%0d pulses exp=0", viol_seen); end
    checks++; if (err_code !== 3'b010) begin errors++; $display("FAIL conflict_hold_code got=%b exp=010", err_code); end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(G, R, 1'b0, 2);
    drive(R, R, 1'b0, 1);
    checks++; if (err_code !== 3'b100 || viol !== 1'b1) begin errors++; $display("FAIL illegal_g2r got code=%b viol=%b exp 100 1", err_code, viol); end
    drive(3'b110, R, 1'b0, 1);
    checks++; if (err_code !== 3'b101 || viol !== 1'b1) begin errors++; $display("FAIL illegal_onehot got code=%b viol=%b exp 101 1", err_code, viol); end
  endtask

  task automatic test_timing();
    do_reset();
    drive(G, R, 1'b0, 12);
    drive(Y, R, 1'b0, 2);
    drive(R, R, 1'b0, 1);
    checks++; if (err_time !== 2'b01 || viol !== 1'b1) begin errors++; $display("FAIL short_yellow got time=%b viol=%b exp 01 1", err_time, viol); end
    drive(R, R, 1'b0, 2);
    drive(G, R, 1'b0, 4);
    drive(Y, R, 1'b0, 1);
    checks++; if (err_time !== 2'b11 || viol !== 1'b1) begin errors++; $display("FAIL short_green got time=%b viol=%b exp 11 1", err_time, viol); end
    checks++; if (err_code !== 3'b000 || h_green_cnt !== 8'd2) begin errors++; $display("FAIL timing_misc got code=%b hg=%0d exp 000 2", err_code, h_green_cnt); end
  endtask

  task automatic test_clr();
    do_reset();
    drive(G, R, 1'b0, 3);
    drive(G, G, 1'b0, 1);
    drive(G, G, 1'b1, 1);
    checks++; if (err_code !== 3'b010 || viol !== 1'b1) begin errors++; $display("FAIL clr_vs_conflict got code=%b viol=%b exp 010 1", err_code, viol); end
    drive(G, R, 1'b0, 1);
    drive(G, R, 1'b0, 1);
    checks++; if (err_code !== 3'b110) begin errors++; $display("FAIL clr_setup got code=%b exp 110", err_code); end
    drive(G, R, 1'b1, 1);
    checks++; if ({err_code, err_time, viol} !== 6'b0) begin errors++; $display("FAIL clr_alone got=%b exp=000000", {err_code, err_time, viol}); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    drive(G, R, 1'b0, 12);
    drive(Y, R, 1'b0, 1);
    checks++; if (phase_ticks !== 16'd1) begin errors++; $display("FAIL midyel_phase got=%0d exp=1", phase_ticks); end
    rst = 1'b1;
    drive(Y, R, 1'b0, 1);
    checks++; if ({err_code, err_time, viol, h_green_cnt, phase_ticks} !== 30'b0) begin errors++; $display("FAIL midrst_zero got=%h exp=0", {err_code, err_time, viol, h_green_cnt, phase_ticks}); end
    rst = 1'b0;
    drive(R, R, 1'b0, 1);
    checks++; if (err_time !== 2'b00 || err_code !== 3'b000 || phase_ticks !== 16'd0 || h_green_cnt !== 8'd0) begin errors++; $display("FAIL midrst_baseline got time=%b code=%b pt=%0d hg=%0d exp 00 000 0 0", err_time, err_code, phase_ticks, h_green_cnt); end
    drive(R, R, 1'b0, 3);
    checks++; if (phase_ticks !== 16'd3 || err_time !== 2'b00) begin errors++; $display("FAIL midrst_restart got pt=%0d time=%b exp 3 00", phase_ticks, err_time); end
  endtask

  function automatic logic [2:0] rnd_next(input logic [2:0] cur);
    int r;
    r = $urandom_range(0, 99);
    if (r < 90) return cur;
    if (r < 98) return succ(cur);
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    logic [2:0] h, f;
    do_reset();
    h = G; f = R;
    for (int i = 0; i < 600; i++) begin
      h = rnd_next(h);
      f = rnd_next(f);
      rst = ($urandom_range(0, 99) == 0);
      drive(h, f, ($urandom_range(0, 99) < 4), 1);
      checks++;
      if ({err_code, err_time, viol, h_green_cnt, phase_ticks} !== {m0.code, m0.tim, m0.viol, 8'(m0.hg), 16'(m0.ch)}) begin
        errors++;
        $display("FAIL rand_dut0 cyc=%0d got code=%b time=%b viol=%b hg=%0d pt=%0d exp code=%b time=%b viol=%b hg=%0d pt=%0d",
                 i, err_code, err_time, viol, h_green_cnt, phase_ticks, m0.code, m0.tim, m0.viol, m0.hg, m0.ch);
      end
      checks++;
      if ({e1_code, e1_time, e1_viol, e1_hg, e1_pt} !== {m1.code, m1.tim, m1.viol, 8'(m1.hg), 16'(m1.ch)}) begin
        errors++;
        $display("FAIL rand_dut1 cyc=%0d got code=%b time=%b viol=%b hg=%0d pt=%0d exp code=%b time=%b viol=%b hg=%0d pt=%0d",
                 i, e1_code, e1_time, e1_viol, e1_hg, e1_pt, m1.code, m1.tim, m1.viol, m1.hg, m1.ch);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_illegal();
    test_timing();
    test_clr();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
